// File: rtl/inverse_rotate_seq.sv
// Model-space inverse of the rotate/translate pipeline: q = M^T * (p - t) >>> 6, clamped.
// Latency 11 cycles from accept to out_valid; result held until out_ready, new input accepted only in IDLE.
module inverse_rotate_seq #(
   parameter int POS_BIT_SIZE = 12
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [POS_BIT_SIZE-1:0] px,
   input  logic signed [POS_BIT_SIZE-1:0] py,
   input  logic signed [POS_BIT_SIZE-1:0] pz,
   input  logic signed [7:0]              m00,
   input  logic signed [7:0]              m01,
   input  logic signed [7:0]              m02,
   input  logic signed [7:0]              m10,
   input  logic signed [7:0]              m11,
   input  logic signed [7:0]              m12,
   input  logic signed [7:0]              m20,
   input  logic signed [7:0]              m21,
   input  logic signed [7:0]              m22,
   input  logic signed [POS_BIT_SIZE-1:0] tx,
   input  logic signed [POS_BIT_SIZE-1:0] ty,
   input  logic signed [POS_BIT_SIZE-1:0] tz,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [POS_BIT_SIZE-1:0] qx,
   output logic signed [POS_BIT_SIZE-1:0] qy,
   output logic signed [POS_BIT_SIZE-1:0] qz,
   output logic                           sat
);
   localparam int P  = POS_BIT_SIZE;
   localparam int DW = P + 1;
   localparam int PW = P + 9;
   localparam int AW = P + 12;
   localparam logic signed [AW-1:0] QMAX = AW'((1 << (P - 1)) - 1);
   localparam logic signed [AW-1:0] QMIN = ~QMAX;

   typedef enum logic [1:0] {IDLE, SUB, MAC, OUT} state_t;

   state_t                 state;
   logic [3:0]             k;
   logic [1:0]             row;
   logic [1:0]             col;
   logic signed [7:0]      m_l [3][3];
   logic signed [P-1:0]    p_l [3];
   logic signed [P-1:0]    t_l [3];
   logic signed [DW-1:0]   d   [3];
   logic signed [AW-1:0]   acc;
   logic [2:0]             satf;

   logic signed [PW-1:0]   prod;
   logic signed [AW-1:0]   sum;
   logic signed [AW-1:0]   shf;
   logic signed [P-1:0]    qc;
   logic                   ovf;

   assign in_ready = (state == IDLE) && !reset;

   // Transpose: column c of the forward matrix weights the row differences.
   always_comb begin
      prod = PW'(m_l[row][col]) * PW'(d[row]);
      sum  = ((row == 2'd0) ? '0 : acc) + AW'(prod);
      shf  = sum >>> 6;
      qc   = shf[P-1:0];
      ovf  = 1'b0;
      if (shf > QMAX) begin
         qc  = QMAX[P-1:0];
         ovf = 1'b1;
      end else if (shf < QMIN) begin
         qc  = QMIN[P-1:0];
         ovf = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         row       <= '0;
         col       <= '0;
         acc       <= '0;
         satf      <= '0;
         out_valid <= 1'b0;
         qx        <= '0;
         qy        <= '0;
         qz        <= '0;
         sat       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  p_l[0]    <= px;  p_l[1]    <= py;  p_l[2]    <= pz;
                  t_l[0]    <= tx;  t_l[1]    <= ty;  t_l[2]    <= tz;
                  m_l[0][0] <= m00; m_l[0][1] <= m01; m_l[0][2] <= m02;
                  m_l[1][0] <= m10; m_l[1][1] <= m11; m_l[1][2] <= m12;
                  m_l[2][0] <= m20; m_l[2][1] <= m21; m_l[2][2] <= m22;
                  state     <= SUB;
               end
            end
            SUB: begin
               for (int i = 0; i < 3; i++)
                  d[i] <= DW'(p_l[i]) - DW'(t_l[i]);
               acc   <= '0;
               k     <= '0;
               row   <= '0;
               col   <= '0;
               satf  <= '0;
               state <= MAC;
            end
            MAC: begin
               acc <= sum;
               k   <= k + 4'd1;
               if (row == 2'd2) begin
                  case (col)
                     2'd0:    qx <= qc;
                     2'd1:    qy <= qc;
                     default: qz <= qc;
                  endcase
                  satf[col] <= ovf;
                  row       <= '0;
                  col       <= col + 2'd1;
               end else begin
                  row <= row + 2'd1;
               end
               if (k == 4'd8) begin
                  sat       <= satf[0] | satf[1] | ovf;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inverse_rotate_seq.sv
// Scoreboard bench for inverse_rotate_seq: driver queues expected results, negedge monitor checks them.
module tb_inverse_rotate_seq;
   typedef struct packed {
      logic signed [11:0] qx;
      logic signed [11:0] qy;
      logic signed [11:0] qz;
      logic               s;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic in_valid, in_ready, out_valid, out_ready, sat;
   logic signed [11:0] p_in [3];
   logic signed [11:0] t_in [3];
   logic signed [7:0]  mm [3][3];
   logic signed [11:0] qx, qy, qz;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t expq [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inverse_rotate_seq #(.POS_BIT_SIZE(12)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .px(p_in[0]), .py(p_in[1]), .pz(p_in[2]),
      .m00(mm[0][0]), .m01(mm[0][1]), .m02(mm[0][2]),
      .m10(mm[1][0]), .m11(mm[1][1]), .m12(mm[1][2]),
      .m20(mm[2][0]), .m21(mm[2][1]), .m22(mm[2][2]),
      .tx(t_in[0]), .ty(t_in[1]), .tz(t_in[2]),
      .out_valid(out_valid), .out_ready(out_ready),
      .qx(qx), .qy(qy), .qz(qz), .sat(sat)
   );

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int x, input int y, input int z, input bit s);
      exp_t e;
      e.qx = 12'(x);
      e.qy = 12'(y);
      e.qz = 12'(z);
      e.s  = s;
      return e;
   endfunction

   // Reference: integer math, >>> on int floors toward -inf, then clamp.
   function automatic exp_t model();
      int  d [3];
      int  qv [3];
      int  s;
      bit  sf = 1'b0;
      for (int r = 0; r < 3; r++) d[r] = int'(p_in[r]) - int'(t_in[r]);
      for (int c = 0; c < 3; c++) begin
         s = 0;
         for (int r = 0; r < 3; r++) s += int'(mm[r][c]) * d[r];
         s = s >>> 6;
         if (s > 2047) begin s = 2047; sf = 1'b1; end
         else if (s < -2048) begin s = -2048; sf = 1'b1; end
         qv[c] = s;
      end
      return mk(qv[0], qv[1], qv[2], sf);
   endfunction

   task automatic setm(input int a, input int b, input int c, input int d, input int e,
                       input int f, input int g, input int h, input int i);
      mm[0][0] = 8'(a); mm[0][1] = 8'(b); mm[0][2] = 8'(c);
      mm[1][0] = 8'(d); mm[1][1] = 8'(e); mm[1][2] = 8'(f);
      mm[2][0] = 8'(g); mm[2][1] = 8'(h); mm[2][2] = 8'(i);
   endtask

   task automatic setpt(input int a, input int b, input int c, input int x, input int y, input int z);
      p_in[0] = 12'(a); p_in[1] = 12'(b); p_in[2] = 12'(c);
      t_in[0] = 12'(x); t_in[1] = 12'(y); t_in[2] = 12'(z);
   endtask

   // Entered and left at a negedge; acyc is the cycle whose closing edge accepted.
   task automatic send(input exp_t e, input bit push, input bit keep, output int acyc);
      int n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      acyc = cyc;
      if (push) expq.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_valid(output int vc);
      int n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", 0, 1);
      vc = cyc;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("qx", 48'(qx), 48'(e.qx));
            chk("qy", 48'(qy), 48'(e.qy));
            chk("qz", 48'(qz), 48'(e.qz));
            chk("sat", 48'(sat), 48'(e.s));
         end
      end
   end

   initial begin
      int a, v, prev;
      exp_t e;
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      setm(64, 0, 0, 0, 64, 0, 0, 0, 64);
      setpt(100, 200, 300, 10, 20, 30);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 48'(in_ready), 0);
      chk("rst_out_valid", 48'(out_valid), 0);
      chk("rst_q", 48'({qx, qy, qz, sat}), 0);
      in_valid = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 48'(in_ready), 1);

      // identity with latency
      send(mk(90, 180, 270, 0), 1, 0, a);
      wait_valid(v);
      chk("latency", 48'(v - a), 11);
      @(negedge clk);

      // 90 degrees about z
      setm(0, -64, 0, 64, 0, 0, 0, 0, 64);
      send(mk(180, -90, 270, 0), 1, 0, a);
      wait_valid(v);
      @(negedge clk);

      // positive clamp, negative clamp, floor of -0.5
      setm(127, 0, 0, 0, 127, 0, 0, 0, 127);
      setpt(2000, 0, 0, 0, 0, 0);
      send(mk(2047, 0, 0, 1), 1, 0, a);
      wait_valid(v);
      @(negedge clk);
      setpt(-2000, 0, 0, 0, 0, 0);
      send(mk(-2048, 0, 0, 1), 1, 0, a);
      wait_valid(v);
      @(negedge clk);
      setm(32, 0, 0, 0, 32, 0, 0, 0, 32);
      setpt(-1, 0, 0, 0, 0, 0);
      send(mk(-1, 0, 0, 0), 1, 0, a);
      wait_valid(v);
      @(negedge clk);

      // backpressure hold for 20 cycles with inputs changing underneath
      out_ready = 1'b0;
      setm(0, -64, 0, 64, 0, 0, 0, 0, 64);
      setpt(100, 200, 300, 10, 20, 30);
      e = mk(180, -90, 270, 0);
      send(e, 1, 0, a);
      wait_valid(v);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 5) begin
            p_in[0] = -12'sd777;
            mm[0][0] = 8'sd5;
            mm[1][0] = -8'sd3;
         end
         chk("hold_q", 48'({qx, qy, qz, sat}), 48'(e));
         chk("hold_valid_ready", 48'({out_valid, in_ready}), 48'(2'b10));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_ready_valid", 48'({in_ready, out_valid}), 48'(2'b10));

      // reset in the middle of MAC discards the result
      setm(64, 0, 0, 0, 64, 0, 0, 0, 64);
      setpt(100, 200, 300, 10, 20, 30);
      send(mk(0, 0, 0, 0), 0, 0, a);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 48'(in_ready), 0);
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 0) chk("midrst_ready_after", 48'(in_ready), 1);
         chk("midrst_quiet", 48'({out_valid, qx, qy, qz, sat}), 0);
      end
      send(mk(90, 180, 270, 0), 1, 0, a);
      wait_valid(v);
      @(negedge clk);

      // back-to-back, in_valid held high, 12-cycle initiation interval
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin setm(50, -20, 3, -64, 127, -128, 10, 0, -90); setpt(-500, 1200, -7, 33, -44, 5); end
            1: begin setm(-128, -128, -128, -128, -128, -128, -128, -128, -128); setpt(2047, 2047, 2047, -2048, -2048, -2048); end
            2: begin setm(45, -45, 0, 45, 45, 0, 0, 0, 64); setpt(-3, 7, -1, 1, 2, 3); end
            default: begin setm(1, 2, 3, 4, 5, 6, 7, 8, 9); setpt(-2048, 1000, -999, 2047, 0, 1); end
         endcase
         send(model(), 1, 1, a);
         if (i > 0) chk("ii", 48'(a - prev), 12);
         prev = a;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
      chk("queue_drained", 48'(expq.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/inverse_rotate_seq.md
# inverse_rotate_seq

Sequential inverse of the per-axis rotate/translate pipeline. Takes a display-space coordinate, removes the translation, and multiplies by the transpose of the same 3x3 coefficient matrix the forward rotators use. The result is the model-space coordinate, used for hit-testing and voxel lookup. One shared signed multiplier is time-multiplexed over nine MAC cycles behind a valid/ready handshake, trading throughput for area.

## Interface
- POS_BIT_SIZE, 12, width of each coordinate and translate component (signed two's complement)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  coordinate and matrix presented
- in_ready  out  1  block can accept (high only in IDLE)
- px, py, pz  in  POS_BIT_SIZE each  display-space coordinate
- m00..m22  in  8 each  forward matrix coefficients, row r = forward output axis r, column c = input axis c; signed Q1.6 (64 = 1.0)
- tx, ty, tz  in  POS_BIT_SIZE each  forward translate per axis
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- qx, qy, qz  out  POS_BIT_SIZE each  model-space coordinate
- sat  out  1  at least one of qx/qy/qz was clamped

## Operation
- Transfer on input when in_valid && in_ready. Transfer on output when out_valid && out_ready.
- On input transfer, latch p, t and all nine coefficients. Later changes on the inputs have no effect on the operation in flight.
- Difference: d_r = p_r - t_r, computed at POS_BIT_SIZE+1 bits signed with no wrap.
- Inverse: q_c = (sum over r of m_rc * d_r) >>> 6. This uses the transpose, i.e. column c of the forward matrix.
  - Product width POS_BIT_SIZE+9.
  - Accumulator width POS_BIT_SIZE+12, signed.
  - The arithmetic shift floors toward -inf.
- Saturation: each q_c is clamped to [-2^(P-1), 2^(P-1)-1]. sat = OR of the three clamp flags.
- FSM states:
  - IDLE: in_ready=1. On input transfer go to SUB.
  - SUB: compute d; clear the accumulator. Go to MAC with k=0.
  - MAC: k = 0..8, one product per cycle in order (c,r) = (0,0),(0,1),(0,2),(1,0)…(2,2).
    - Accumulator clears when starting a new column.
    - Clamped column result is written to q_c when r=2.
    - After k=8, go to OUT.
  - OUT: out_valid=1, outputs stable. On output transfer go to IDLE.
- No overlap: a new input is not accepted until the result is taken.

## Timing
- Reset values: in_ready=0 during reset, 1 on the first cycle after reset deasserts.
  - out_valid=0, qx=qy=qz=0, sat=0.
  - FSM goes to IDLE; the accumulator and k are cleared.
- Latency: input transfer at edge 0 → out_valid high after edge 11 (1 SUB + 9 MAC + 1 register).
- With out_ready held high, the minimum initiation interval is 12 cycles.
- out_valid and q* remain constant while out_ready=0, for any duration.
- in_ready is combinational from state only; it never depends on in_valid.
- Reset mid-operation (SUB/MAC/OUT) aborts the operation. The pending result is discarded; out_valid is never asserted for it.
- in_valid asserted during reset is ignored.

## Test plan
- Identity: diag=64, off=0, p=(100,200,300), t=(10,20,30) → q=(90,180,270), sat=0, out_valid 11 cycles after accept.
- 90° about z: forward rows m0=(0,-64,0), m1=(64,0,0), m2=(0,0,64); same p and t → q=(180,-90,270).
- Saturation and floor, both with identity matrix except as noted:
  - diag=127, p=(2000,0,0), t=0 → qx=2047 (raw 3968), sat=1.
  - p=(-2000,0,0) → qx=-2048, sat=1.
  - diag=32, p=(-1,0,0), t=0 → qx=-1, sat=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - Outputs must remain stable and in_ready=0 throughout.
  - Change p/m inputs during the hold; the held result must not change.
  - Release out_ready → one transfer, in_ready=1 on the next cycle.
- Reset mid-MAC: pulse reset at cycle 5 after accept → out_valid stays 0, outputs 0, in_ready=1 after release. A fresh identity transaction then returns the correct result.
- Back-to-back: 4 random transactions with out_ready=1 and in_valid held high.
  - Accepts are spaced exactly 12 cycles apart.
  - Each result matches a bit-exact reference model including the floor shift and clamp.
